// File: rtl/tcp_pkg.sv
// Shared TCP datapath types: TX control commands issued by the per-connection
// state managers to the TX packet generator.
package tcp_pkg;

  typedef enum logic [2:0] {
    TX_CTRL_NOP       = 3'd0,
    TX_CTRL_SEND_SYN  = 3'd1,
    TX_CTRL_SEND_SYNACK = 3'd2,
    TX_CTRL_SEND_ACK  = 3'd3,
    TX_CTRL_SEND_FIN  = 3'd4,
    TX_CTRL_SEND_RST  = 3'd5,
    TX_CTRL_SEND_DATA = 3'd6,
    TX_CTRL_SEND_KEEPALIVE = 3'd7
  } tx_ctrl_t;

endpackage

// File: rtl/tcp_tx_ctrl_arbiter.sv
// Round-robin arbiter sharing one TX packet generator between NUM_STREAMS
// tcp_state_manager requesters; one command per two cycles at peak.
module tcp_tx_ctrl_arbiter #(
  parameter int unsigned NUM_STREAMS = 4,
  parameter int unsigned IDX_W       = $clog2(NUM_STREAMS)
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic                                i_enable,
  input  tcp_pkg::tx_ctrl_t [NUM_STREAMS-1:0] i_tx_ctrl,
  input  logic [NUM_STREAMS-1:0]              i_tx_ctrl_valid,
  output logic [NUM_STREAMS-1:0]              o_tx_ctrl_ack,
  output tcp_pkg::tx_ctrl_t                   o_tx_ctrl,
  output logic [IDX_W-1:0]                    o_tx_ctrl_stream,
  output logic                                o_tx_ctrl_valid,
  input  logic                                i_tx_ctrl_ack
);

  import tcp_pkg::*;

  localparam int unsigned CW = IDX_W + 1;

  typedef enum logic {
    ARB   = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state;
  logic [IDX_W-1:0]  gidx;
  logic [IDX_W-1:0]  rr_ptr;
  tx_ctrl_t          gcmd;

  logic              found_c;
  logic [IDX_W-1:0]  sel_c;
  logic [CW-1:0]     cand_c;
  logic              grant_active_c;
  logic              gvalid_c;
  logic              handshake_c;
  logic [IDX_W-1:0]  rr_next_c;

  // First requester at or after rr_ptr, wrapping past the last stream.
  always_comb begin
    found_c = 1'b0;
    sel_c   = '0;
    cand_c  = '0;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      cand_c = {1'b0, rr_ptr} + CW'(k);
      if (cand_c >= CW'(NUM_STREAMS)) begin
        cand_c = cand_c - CW'(NUM_STREAMS);
      end
      if (!found_c && i_tx_ctrl_valid[IDX_W'(cand_c)]) begin
        found_c = 1'b1;
        sel_c   = IDX_W'(cand_c);
      end
    end
  end

  // Disable and reset both suppress the grant in the cycle they are seen.
  assign grant_active_c = (state == GRANT) && i_enable && !i_rst;
  assign gvalid_c       = i_tx_ctrl_valid[gidx];
  assign handshake_c    = grant_active_c && gvalid_c && i_tx_ctrl_ack;
  assign rr_next_c      = (gidx == IDX_W'(NUM_STREAMS - 1)) ? '0 : gidx + IDX_W'(1);

  always_comb begin
    o_tx_ctrl_ack = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      o_tx_ctrl_ack[i] = handshake_c && (gidx == IDX_W'(i));
    end
  end

  assign o_tx_ctrl_valid  = grant_active_c && gvalid_c;
  assign o_tx_ctrl        = grant_active_c ? gcmd : TX_CTRL_NOP;
  assign o_tx_ctrl_stream = grant_active_c ? gidx : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ARB;
      rr_ptr <= '0;
      gidx   <= '0;
      gcmd   <= TX_CTRL_NOP;
    end else if (!i_enable) begin
      state  <= ARB;
      rr_ptr <= '0;
    end else begin
      case (state)
        ARB: begin
          if (found_c) begin
            state <= GRANT;
            gidx  <= sel_c;
            gcmd  <= i_tx_ctrl[sel_c];
          end
        end
        GRANT: begin
          // A withdrawn request releases the grant without moving the pointer.
          if (!gvalid_c) begin
            state <= ARB;
          end else if (i_tx_ctrl_ack) begin
            state  <= ARB;
            rr_ptr <= rr_next_c;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_tx_ctrl_arbiter.sv
// Bench for tcp_tx_ctrl_arbiter: directed scenarios plus a randomized run
// checked cycle-by-cycle against a transaction-level reference model.
module tb_tcp_tx_ctrl_arbiter;
  import tcp_pkg::*;

  localparam int N = 4;

  logic             clk;
  logic             rst;
  logic             en;
  tx_ctrl_t [N-1:0] ctrl;
  logic [N-1:0]     vld;
  logic [N-1:0]     ack_o;
  tx_ctrl_t         cmd_o;
  logic [1:0]       stream_o;
  logic             vout;
  logic             ds_ack;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: granted stream (-1 when selecting), pointer, held command.
  int       m_gnt = -1;
  int       m_ptr = 0;
  tx_ctrl_t m_cmd = TX_CTRL_NOP;

  tcp_tx_ctrl_arbiter #(.NUM_STREAMS(N)) dut (
    .i_clk            (clk),
    .i_rst            (rst),
    .i_enable         (en),
    .i_tx_ctrl        (ctrl),
    .i_tx_ctrl_valid  (vld),
    .o_tx_ctrl_ack    (ack_o),
    .o_tx_ctrl        (cmd_o),
    .o_tx_ctrl_stream (stream_o),
    .o_tx_ctrl_valid  (vout),
    .i_tx_ctrl_ack    (ds_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_advance();
    if (rst) begin
      m_gnt = -1; m_ptr = 0; m_cmd = TX_CTRL_NOP;
    end else if (!en) begin
      m_gnt = -1; m_ptr = 0;
    end else if (m_gnt < 0) begin
      for (int k = 0; k < N; k++) begin
        int s;
        s = (m_ptr + k) % N;
        if (vld[s]) begin
          m_gnt = s; m_cmd = ctrl[s];
          break;
        end
      end
    end else if (!vld[m_gnt]) begin
      m_gnt = -1;
    end else if (ds_ack) begin
      m_ptr = (m_gnt + 1) % N;
      m_gnt = -1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; vld = 4'b1111; ds_ack = 1'b1;
    step();
    step();
    #1;
    n_total++;
    if (vout !== 1'b0 || ack_o !== 4'b0 || cmd_o !== TX_CTRL_NOP || stream_o !== 2'd0)
      $display("FAIL reset_hold: valid=%b ack=%b cmd=%0d stream=%0d required 0/0000/NOP/0", vout, ack_o, cmd_o, stream_o);
    else n_pass++;
    rst = 1'b0; vld = 4'b0; ds_ack = 1'b0;
    #1;
    n_total++;
    if (vout !== 1'b0 || ack_o !== 4'b0 || cmd_o !== TX_CTRL_NOP || stream_o !== 2'd0)
      $display("FAIL reset_after: valid=%b ack=%b cmd=%0d stream=%0d required 0/0000/NOP/0", vout, ack_o, cmd_o, stream_o);
    else n_pass++;
    step();
  endtask

  task automatic test_single();
    vld = 4'b0100; ctrl[2] = TX_CTRL_SEND_SYN;
    #1;
    n_total++;
    if (vout !== 1'b0 || ack_o !== 4'b0)
      $display("FAIL single_arb: valid=%b ack=%b required 0/0000", vout, ack_o);
    else n_pass++;
    step();
    n_total++;
    if (vout !== 1'b1 || stream_o !== 2'd2 || cmd_o !== TX_CTRL_SEND_SYN || ack_o !== 4'b0)
      $display("FAIL single_grant: valid=%b stream=%0d cmd=%0d ack=%b required 1/2/1/0000", vout, stream_o, cmd_o, ack_o);
    else n_pass++;
    ds_ack = 1'b1;
    #1;
    n_total++;
    if (ack_o !== 4'b0100 || vout !== 1'b1)
      $display("FAIL single_ack: ack=%b valid=%b required 0100/1", ack_o, vout);
    else n_pass++;
    step();
    vld = 4'b0; ds_ack = 1'b0;
    // Pointer should now be 3: with streams 0 and 3 pending, 3 wins.
    vld = 4'b1001;
    step();
    n_total++;
    if (stream_o !== 2'd3 || vout !== 1'b1)
      $display("FAIL single_rrptr: stream=%0d valid=%b required 3/1", stream_o, vout);
    else n_pass++;
    ds_ack = 1'b1;
    step();
    vld = 4'b0; ds_ack = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    int order[5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < N; i++) ctrl[i] = tx_ctrl_t'(3'(i + 3));
    vld = 4'b1111; ds_ack = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      n_total++;
      if (vout !== 1'b0 || ack_o !== 4'b0)
        $display("FAIL b2b_gap%0d: valid=%b ack=%b required 0/0000", g, vout, ack_o);
      else n_pass++;
      step();
      n_total++;
      if (vout !== 1'b1 || stream_o !== 2'(order[g]) || ack_o !== 4'(1 << order[g]) ||
          cmd_o !== tx_ctrl_t'(3'(order[g] + 3)))
        $display("FAIL b2b_grant%0d: valid=%b stream=%0d ack=%b cmd=%0d required 1/%0d/%b/%0d",
                 g, vout, stream_o, ack_o, cmd_o, order[g], 4'(1 << order[g]), order[g] + 3);
      else n_pass++;
      step();
    end
    vld = 4'b0; ds_ack = 1'b0;
    step();
  endtask

  task automatic test_hold();
    vld = 4'b0010; ctrl[1] = TX_CTRL_SEND_ACK;
    step();
    for (int c = 0; c < 5; c++) begin
      ctrl[1] = tx_ctrl_t'(3'($urandom));
      #1;
      n_total++;
      if (vout !== 1'b1 || cmd_o !== TX_CTRL_SEND_ACK || stream_o !== 2'd1 || ack_o !== 4'b0)
        $display("FAIL hold%0d: valid=%b cmd=%0d stream=%0d ack=%b required 1/3/1/0000", c, vout, cmd_o, stream_o, ack_o);
      else n_pass++;
      step();
    end
    ds_ack = 1'b1;
    #1;
    n_total++;
    if (ack_o !== 4'b0010 || cmd_o !== TX_CTRL_SEND_ACK)
      $display("FAIL hold_ack: ack=%b cmd=%0d required 0010/3", ack_o, cmd_o);
    else n_pass++;
    step();
    vld = 4'b0; ds_ack = 1'b0;
    step();
  endtask

  task automatic test_withdraw();
    vld = 4'b1000; ctrl[3] = TX_CTRL_SEND_FIN;
    step();
    vld = 4'b0000; ds_ack = 1'b1;
    #1;
    n_total++;
    if (vout !== 1'b0 || ack_o !== 4'b0)
      $display("FAIL withdraw: valid=%b ack=%b required 0/0000", vout, ack_o);
    else n_pass++;
    step();
    ds_ack = 1'b0;
    // Pointer still 2: from streams 1 and 3 pending, 3 wins.
    vld = 4'b1010;
    #1;
    n_total++;
    if (vout !== 1'b0)
      $display("FAIL withdraw_arb: valid=%b required 0", vout);
    else n_pass++;
    step();
    n_total++;
    if (stream_o !== 2'd3 || vout !== 1'b1)
      $display("FAIL withdraw_rrptr: stream=%0d valid=%b required 3/1", stream_o, vout);
    else n_pass++;
    ds_ack = 1'b1;
    step();
    vld = 4'b0; ds_ack = 1'b0;
    step();
  endtask

  task automatic test_enable_reset();
    vld = 4'b0001; ctrl[0] = TX_CTRL_SEND_RST;
    step();
    ds_ack = 1'b1;
    step();
    ds_ack = 1'b0;
    step();
    // Pointer is 1 and stream 0 is granted again; disable mid-grant.
    en = 1'b0; ds_ack = 1'b1;
    #1;
    n_total++;
    if (vout !== 1'b0 || ack_o !== 4'b0 || cmd_o !== TX_CTRL_NOP || stream_o !== 2'd0)
      $display("FAIL disable: valid=%b ack=%b cmd=%0d stream=%0d required 0/0000/NOP/0", vout, ack_o, cmd_o, stream_o);
    else n_pass++;
    step();
    en = 1'b1; ds_ack = 1'b0; vld = 4'b0011;
    step();
    n_total++;
    if (vout !== 1'b1 || stream_o !== 2'd0)
      $display("FAIL disable_recover: valid=%b stream=%0d required 1/0", vout, stream_o);
    else n_pass++;
    ds_ack = 1'b1;
    step();
    ds_ack = 1'b0;
    step();
    // Stream 1 now granted; reset mid-grant must not ack.
    rst = 1'b1; ds_ack = 1'b1;
    #1;
    n_total++;
    if (vout !== 1'b0 || ack_o !== 4'b0 || cmd_o !== TX_CTRL_NOP || stream_o !== 2'd0)
      $display("FAIL reset_grant: valid=%b ack=%b cmd=%0d stream=%0d required 0/0000/NOP/0", vout, ack_o, cmd_o, stream_o);
    else n_pass++;
    step();
    rst = 1'b0; ds_ack = 1'b0;
    step();
    n_total++;
    if (vout !== 1'b1 || stream_o !== 2'd0)
      $display("FAIL reset_recover: valid=%b stream=%0d required 1/0", vout, stream_o);
    else n_pass++;
    ds_ack = 1'b1;
    step();
    vld = 4'b0; ds_ack = 1'b0;
    step();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int c = 0; c < 600; c++) begin
      bit       active;
      logic     e_valid;
      logic [N-1:0] e_ack;
      tx_ctrl_t e_cmd;
      logic [1:0] e_stream;
      vld    = 4'($urandom) | 4'($urandom);
      ds_ack = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) ctrl[i] = tx_ctrl_t'(3'($urandom));
      en  = ($urandom_range(0, 29) != 0);
      rst = ($urandom_range(0, 49) == 0);
      #1;
      active   = (m_gnt >= 0) && en && !rst;
      e_valid  = active ? vld[m_gnt] : 1'b0;
      e_ack    = (e_valid && ds_ack) ? 4'(1 << m_gnt) : 4'b0;
      e_cmd    = active ? m_cmd : TX_CTRL_NOP;
      e_stream = active ? 2'(m_gnt) : 2'd0;
      n_total++;
      if (vout !== e_valid || ack_o !== e_ack || cmd_o !== e_cmd || stream_o !== e_stream) begin
        if (errs < 10)
          $display("FAIL random_c%0d: valid=%b ack=%b cmd=%0d stream=%0d required %b/%b/%0d/%0d",
                   c, vout, ack_o, cmd_o, stream_o, e_valid, e_ack, e_cmd, e_stream);
        errs++;
      end else n_pass++;
      step();
    end
    rst = 1'b0; en = 1'b1; vld = 4'b0; ds_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b1; vld = '0; ds_ack = 1'b0;
    for (int i = 0; i < N; i++) ctrl[i] = TX_CTRL_NOP;
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_withdraw();
    test_enable_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
